// File: rtl/cache_fill_if.sv
// cache_fill_if: miss request, memory return and fill outputs between L1 cache, memory and the fill FSM
interface cache_fill_if;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        memory_enable;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [7:0]  data_word_enable;
  logic [15:0] data_array_wdata;
  logic        write_tag_array;
  logic [15:0] fill_address;
  modport master (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, memory_enable, memory_address, write_data_array,
           data_word_enable, data_array_wdata, write_tag_array, fill_address
  );
  modport slave (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, memory_enable, memory_address, write_data_array,
           data_word_enable, data_array_wdata, write_tag_array, fill_address
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: issues eight word reads per missed block and steers returning words into the data array
module cache_fill_fsm (
  input logic         clk,
  input logic         rst_n,
  cache_fill_if.slave bus
);
  localparam logic [3:0] WORDS = 4'd8;
  localparam logic [2:0] LAST = 3'd7;
  typedef enum logic {IDLE, FILL} state_t;
  state_t      state_q, state_d;
  logic [3:0]  issue_cnt_q, issue_cnt_d;
  logic [2:0]  rx_cnt_q, rx_cnt_d;
  logic [15:0] base_q, base_d;
  logic        issuing;
  logic        wr_data;
  logic [7:0]  word_en;
  logic        wr_tag;
  logic [2:0]  addr_word;
  assign issuing = (state_q == FILL) && (issue_cnt_q < WORDS);
  // once all reads are out the address parks on the last word instead of wrapping to the block base
  assign addr_word = issue_cnt_q[3] ? LAST : issue_cnt_q[2:0];
  // state, counters and block base
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
      base_q      <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      base_q      <= base_d;
    end
  end
  // issue and receive sides advance independently; the fill ends on the eighth returned word
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    base_d      = base_q;
    wr_data     = 1'b0;
    word_en     = '0;
    wr_tag      = 1'b0;
    if (state_q == IDLE) begin
      if (bus.miss_detected) begin
        state_d     = FILL;
        base_d      = {bus.miss_address[15:4], 4'h0};
        issue_cnt_d = '0;
        rx_cnt_d    = '0;
      end
    end else begin
      issue_cnt_d = issuing ? issue_cnt_q + 4'd1 : issue_cnt_q;
      if (bus.memory_data_valid) begin
        wr_data  = 1'b1;
        word_en  = 8'b1 << rx_cnt_q;
        rx_cnt_d = rx_cnt_q + 3'd1;
        wr_tag   = (rx_cnt_q == LAST);
        state_d  = (rx_cnt_q == LAST) ? IDLE : FILL;
      end
    end
  end
  assign bus.fsm_busy         = (state_q == FILL);
  assign bus.memory_enable    = issuing;
  assign bus.memory_address   = {base_q[15:4], addr_word, 1'b0};
  assign bus.write_data_array = wr_data;
  assign bus.data_word_enable = word_en;
  assign bus.data_array_wdata = bus.memory_data;
  assign bus.write_tag_array  = wr_tag;
  assign bus.fill_address     = base_q;
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed table and sequence checks of cache_fill_fsm against a 4-cycle pipelined memory
module tb_cache_fill_fsm;
  logic clk;
  logic rst_n;
  logic stray;
  int   total = 0;
  int   bad = 0;
  cache_fill_if bus ();
  cache_fill_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  // memory model: data returns on the 4th cycle after the enable cycle; data = address ^ 5A5A
  logic [3:0]  pv = '0;
  logic [15:0] pa [4];
  always @(posedge clk) begin
    pv    <= {pv[2:0], bus.memory_enable};
    pa[0] <= bus.memory_address;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end
  assign bus.memory_data_valid = pv[3] | stray;
  assign bus.memory_data = pv[3] ? (pa[3] ^ 16'h5A5A) : 16'hDEAD;
  typedef struct {
    logic        miss;
    logic        busy;
    logic        en;
    logic [15:0] addr;
    logic [7:0]  wde;
    logic        tag;
    logic [15:0] wdata;
  } vec_t;
  vec_t tbl [14];
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk_quiet(input string nm);
    chk({nm, " busy"}, 16'(bus.fsm_busy), 16'h0);
    chk({nm, " wda"}, 16'(bus.write_data_array), 16'h0);
    chk({nm, " wde"}, 16'(bus.data_word_enable), 16'h0);
    chk({nm, " tag"}, 16'(bus.write_tag_array), 16'h0);
  endtask
  task automatic run_fill(input logic [15:0] maddr, input logic [15:0] base, input logic [11:0] tmask, input string nm);
    int k;
    bus.miss_detected = 1'b1;
    bus.miss_address = maddr;
    @(negedge clk);
    chk($sformatf("%s pre busy", nm), 16'(bus.fsm_busy), 16'h0);
    @(posedge clk); #1;
    for (int f = 0; f < 12; f++) begin
      bus.miss_detected = tmask[f];
      bus.miss_address = tmask[f] ? 16'h4000 : maddr;
      @(negedge clk);
      k = f - 4;
      chk($sformatf("%s busy F%0d", nm, f), 16'(bus.fsm_busy), 16'h1);
      chk($sformatf("%s en F%0d", nm, f), 16'(bus.memory_enable), 16'(f < 8));
      chk($sformatf("%s addr F%0d", nm, f), bus.memory_address, base | 16'(((f < 8) ? f : 7) * 2));
      chk($sformatf("%s wde F%0d", nm, f), 16'(bus.data_word_enable), (f >= 4) ? 16'(1 << k) : 16'h0);
      chk($sformatf("%s tag F%0d", nm, f), 16'(bus.write_tag_array), 16'(f == 11));
      chk($sformatf("%s fill F%0d", nm, f), bus.fill_address, base);
      if (f >= 4)
        chk($sformatf("%s wdata F%0d", nm, f), bus.data_array_wdata, {base[15:4], 3'(k), 1'b0} ^ 16'h5A5A);
      @(posedge clk); #1;
    end
    bus.miss_detected = 1'b0;
    bus.miss_address = maddr;
    @(negedge clk);
    chk($sformatf("%s end busy", nm), 16'(bus.fsm_busy), 16'h0);
    chk($sformatf("%s end en", nm), 16'(bus.memory_enable), 16'h0);
    @(posedge clk); #1;
  endtask
  initial begin
    int ntags, t1, t2, lows, busy_n, n;
    logic seen_busy, seen2;
    //           miss busy en  addr      wde    tag  wdata
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 16'h1230, 8'h00, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 16'h1232, 8'h00, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'h1234, 8'h00, 1'b0, 16'h0000};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 16'h1236, 8'h00, 1'b0, 16'h0000};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 16'h1238, 8'h01, 1'b0, 16'h486A};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 16'h123A, 8'h02, 1'b0, 16'h4868};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 16'h123C, 8'h04, 1'b0, 16'h486E};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 16'h123E, 8'h08, 1'b0, 16'h486C};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'h123E, 8'h10, 1'b0, 16'h4862};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 16'h123E, 8'h20, 1'b0, 16'h4860};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 16'h123E, 8'h40, 1'b0, 16'h4866};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 16'h123E, 8'h80, 1'b1, 16'h4864};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 16'h123E, 8'h00, 1'b0, 16'h0000};
    rst_n = 1'b0;
    stray = 1'b0;
    bus.miss_detected = 1'b0;
    bus.miss_address = 16'h0;
    @(negedge clk);
    chk_quiet("reset");
    chk("reset en", 16'(bus.memory_enable), 16'h0);
    chk("reset addr", bus.memory_address, 16'h0);
    chk("reset fill", bus.fill_address, 16'h0);
    chk("reset wdata", bus.data_array_wdata, bus.memory_data);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.miss_address = 16'h1236;
    for (int i = 0; i < 14; i++) begin
      bus.miss_detected = tbl[i].miss;
      @(negedge clk);
      chk($sformatf("tbl%0d busy", i), 16'(bus.fsm_busy), 16'(tbl[i].busy));
      chk($sformatf("tbl%0d en", i), 16'(bus.memory_enable), 16'(tbl[i].en));
      chk($sformatf("tbl%0d addr", i), bus.memory_address, tbl[i].addr);
      chk($sformatf("tbl%0d wde", i), 16'(bus.data_word_enable), 16'(tbl[i].wde));
      chk($sformatf("tbl%0d wda", i), 16'(bus.write_data_array), 16'(tbl[i].wde != 8'h0));
      chk($sformatf("tbl%0d tag", i), 16'(bus.write_tag_array), 16'(tbl[i].tag));
      if (tbl[i].busy)
        chk($sformatf("tbl%0d fill", i), bus.fill_address, 16'h1230);
      if (tbl[i].wde != 8'h0)
        chk($sformatf("tbl%0d wdata", i), bus.data_array_wdata, tbl[i].wdata);
      @(posedge clk); #1;
    end
    run_fill(16'hFFFE, 16'hFFF0, 12'h000, "top");
    run_fill(16'h1236, 16'h1230, 12'h0A4, "ignore");
    stray = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_quiet($sformatf("stray%0d", i));
      @(posedge clk); #1;
      stray = (i != 1);
    end
    stray = 1'b0;
    run_fill(16'h2468, 16'h2460, 12'h000, "afterstray");
    bus.miss_detected = 1'b1;
    bus.miss_address = 16'h5550;
    @(posedge clk); #1;
    bus.miss_detected = 1'b0;
    for (int f = 0; f < 6; f++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk_quiet("midrst");
    chk("midrst en", 16'(bus.memory_enable), 16'h0);
    chk("midrst addr", bus.memory_address, 16'h0);
    chk("midrst fill", bus.fill_address, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_quiet($sformatf("stale%0d", i));
      chk($sformatf("stale%0d en", i), 16'(bus.memory_enable), 16'h0);
      @(posedge clk); #1;
    end
    run_fill(16'h7772, 16'h7770, 12'h000, "postrst");
    ntags = 0; t1 = 0; t2 = 0; lows = 0; busy_n = 0;
    seen_busy = 1'b0; seen2 = 1'b0;
    bus.miss_detected = 1'b1;
    bus.miss_address = 16'hA000;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.fsm_busy) busy_n++;
      if (bus.fsm_busy && !seen_busy)
        chk("b2b fill1", bus.fill_address, 16'hA000);
      if (ntags == 1 && !bus.fsm_busy && !seen2) lows++;
      if (ntags == 1 && bus.fsm_busy && !seen2) begin
        seen2 = 1'b1;
        chk("b2b fill2", bus.fill_address, 16'hB000);
      end
      seen_busy = seen_busy | bus.fsm_busy;
      if (bus.write_tag_array) begin
        ntags++;
        if (ntags == 1) t1 = n;
        else t2 = n;
      end
      @(posedge clk); #1;
      if (seen_busy) bus.miss_address = 16'hB000;
      if (ntags >= 2) bus.miss_detected = 1'b0;
    end
    chk("b2b tags", 16'(ntags), 16'd2);
    chk("b2b gap", 16'(t2 - t1), 16'd13);
    chk("b2b lows", 16'(lows), 16'd1);
    chk("b2b busy", 16'(busy_n), 16'd24);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
